// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD countdown controller driven by an upstream borrow/carry tick.
// Loadable count with a run/hold/done state machine and optional auto reload.
module bcd_countdown_ctrl #(
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       ld,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       run,
  output logic       done,
  output logic       expire
);

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
  localparam bit AR = (AUTO_RELOAD != 0);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t             state;
  logic [DIGIT_W-1:0] rl_tens;
  logic [DIGIT_W-1:0] rl_ones;
  logic [DIGIT_W-1:0] cl_tens;
  logic [DIGIT_W-1:0] cl_ones;
  logic               cnt_zero;
  logic               rl_zero;
  logic               last_tick;

  // Out-of-range load digits saturate to 9.
  assign cl_tens   = (ld_tens > DIGIT_MAX) ? DIGIT_MAX : ld_tens;
  assign cl_ones   = (ld_ones > DIGIT_MAX) ? DIGIT_MAX : ld_ones;
  assign cnt_zero  = (tens == '0) && (ones == '0);
  assign rl_zero   = (rl_tens == '0) && (rl_ones == '0);
  assign last_tick = (tens == '0) && (ones == DIGIT_W'(1));

  // Count, reload register and state machine; priority mr > ld > start > stop > tick.
  always_ff @(posedge clk) begin
    expire <= 1'b0;
    if (mr) begin
      state   <= IDLE;
      tens    <= '0;
      ones    <= '0;
      rl_tens <= '0;
      rl_ones <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else if (ld && (state != RUN)) begin
      state   <= IDLE;
      tens    <= cl_tens;
      ones    <= cl_ones;
      rl_tens <= cl_tens;
      rl_ones <= cl_ones;
      run     <= 1'b0;
      done    <= 1'b0;
    end else if (start && ((state == IDLE) || (state == HOLD))) begin
      if (cnt_zero) begin
        state <= DONE;
        run   <= 1'b0;
        done  <= !AR;
      end else begin
        state <= RUN;
        run   <= 1'b1;
        done  <= 1'b0;
      end
    end else if (stop && (state == RUN)) begin
      state <= HOLD;
      run   <= 1'b0;
    end else if (tick && (state == RUN)) begin
      if (cnt_zero) begin
        // Only reachable with auto reload: this tick restores the reload value.
        tens <= rl_tens;
        ones <= rl_ones;
        if (rl_zero) begin
          state <= DONE;
          run   <= 1'b0;
          done  <= 1'b0;
        end
      end else begin
        if (ones != '0) begin
          ones <= ones - DIGIT_W'(1);
        end else begin
          ones <= DIGIT_MAX;
          tens <= tens - DIGIT_W'(1);
        end
        if (last_tick) begin
          expire <= 1'b1;
          if (!AR || rl_zero) begin
            state <= DONE;
            run   <= 1'b0;
            done  <= !AR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and random
// stimulus compared against a value-level model for both reload modes.
module tb_bcd_countdown_ctrl;

  logic       clk;
  logic       mr, ld, start, stop, tick;
  logic [3:0] ld_tens, ld_ones;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic       run0, done0, expire0, run1, done1, expire1;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_countdown_ctrl #(.AUTO_RELOAD(0)) dut0 (
    .clk(clk), .mr(mr), .ld(ld), .ld_tens(ld_tens), .ld_ones(ld_ones),
    .start(start), .stop(stop), .tick(tick),
    .tens(tens0), .ones(ones0), .run(run0), .done(done0), .expire(expire0));

  bcd_countdown_ctrl #(.AUTO_RELOAD(1)) dut1 (
    .clk(clk), .mr(mr), .ld(ld), .ld_tens(ld_tens), .ld_ones(ld_ones),
    .start(start), .stop(stop), .tick(tick),
    .tens(tens1), .ones(ones1), .run(run1), .done(done1), .expire(expire1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model works on the decimal value 0..99, not on digits.
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;
  typedef struct packed {
    logic [6:0] val;
    logic [6:0] rl;
    logic [1:0] st;
    logic       exp;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, bit ar, bit i_mr, bit i_ld, logic [3:0] lt,
                                logic [3:0] lo, bit i_st, bit i_sp, bit i_tk);
    mdl_t n = m;
    int t, o;
    n.exp = 1'b0;
    t = (lt > 9) ? 9 : int'(lt);
    o = (lo > 9) ? 9 : int'(lo);
    if (i_mr) begin
      n = '0;
    end else if (i_ld && m.st != 2'(S_RUN)) begin
      n.val = 7'(t * 10 + o);
      n.rl  = n.val;
      n.st  = 2'(S_IDLE);
    end else if (i_st && (m.st == 2'(S_IDLE) || m.st == 2'(S_HOLD))) begin
      n.st = (m.val == 0) ? 2'(S_DONE) : 2'(S_RUN);
    end else if (i_sp && m.st == 2'(S_RUN)) begin
      n.st = 2'(S_HOLD);
    end else if (i_tk && m.st == 2'(S_RUN)) begin
      if (m.val == 0) begin
        n.val = m.rl;
        if (m.rl == 0) n.st = 2'(S_DONE);
      end else begin
        n.val = m.val - 7'd1;
        if (n.val == 0) begin
          n.exp = 1'b1;
          if (!ar || m.rl == 0) n.st = 2'(S_DONE);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] expect_of(mdl_t m, bit ar);
    return {4'(m.val / 10), 4'(m.val % 10), m.st == 2'(S_RUN),
            (m.st == 2'(S_DONE)) && !ar, m.exp};
  endfunction

  function automatic logic [10:0] out0();
    return {tens0, ones0, run0, done0, expire0};
  endfunction

  function automatic logic [10:0] out1();
    return {tens1, ones1, run1, done1, expire1};
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got tens=%h ones=%h run=%b done=%b expire=%b, expected tens=%h ones=%h run=%b done=%b expire=%b",
               nm, $time, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive at negedge, sample at the following negedge, check both DUTs vs model.
  task automatic cyc(input bit i_mr, input bit i_ld, input logic [3:0] lt, input logic [3:0] lo,
                     input bit i_st, input bit i_sp, input bit i_tk);
    mr = i_mr; ld = i_ld; ld_tens = lt; ld_ones = lo;
    start = i_st; stop = i_sp; tick = i_tk;
    @(posedge clk);
    @(negedge clk);
    m0 = step(m0, 1'b0, i_mr, i_ld, lt, lo, i_st, i_sp, i_tk);
    m1 = step(m1, 1'b1, i_mr, i_ld, lt, lo, i_st, i_sp, i_tk);
    chk("model_ar0", out0(), expect_of(m0, 1'b0));
    chk("model_ar1", out1(), expect_of(m1, 1'b1));
  endtask

  typedef struct packed {
    logic       mr, ld;
    logic [3:0] lt, lo;
    logic       st, sp, tk;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t v(bit a_mr, bit a_ld, logic [3:0] lt, logic [3:0] lo, bit a_st,
                             bit a_sp, bit a_tk, logic [3:0] et, logic [3:0] eo,
                             bit er, bit ed, bit ee);
    return {a_mr, a_ld, lt, lo, a_st, a_sp, a_tk, et, eo, er, ed, ee};
  endfunction

  vec_t tbl [24];

  initial begin
    m0 = '0; m1 = '0;
    mr = 0; ld = 0; ld_tens = 0; ld_ones = 0; start = 0; stop = 0; tick = 0;
    @(negedge clk);

    //            mr ld  lt    lo  st sp tk  tens ones run done exp   (AUTO_RELOAD=0)
    tbl[0]  = v(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    tbl[1]  = v(0, 1, 4'h1, 4'h2, 0, 0, 0, 4'd1, 4'd2, 0, 0, 0);
    tbl[2]  = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd1, 4'd2, 0, 0, 0);
    tbl[3]  = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd1, 4'd2, 1, 0, 0);
    tbl[4]  = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd1, 4'd1, 1, 0, 0);
    tbl[5]  = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd1, 4'd0, 1, 0, 0);
    tbl[6]  = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd9, 1, 0, 0);
    tbl[7]  = v(0, 1, 4'h5, 4'h5, 0, 0, 1, 4'd0, 4'd8, 1, 0, 0);
    tbl[8]  = v(0, 0, 4'h0, 4'h0, 0, 1, 1, 4'd0, 4'd8, 0, 0, 0);
    tbl[9]  = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd8, 0, 0, 0);
    tbl[10] = v(0, 1, 4'hC, 4'hF, 0, 0, 0, 4'd9, 4'd9, 0, 0, 0);
    tbl[11] = v(0, 1, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    tbl[12] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    tbl[13] = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd0, 0, 1, 0);
    tbl[14] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    tbl[15] = v(0, 1, 4'h0, 4'h3, 0, 0, 0, 4'd0, 4'd3, 0, 0, 0);
    tbl[16] = v(0, 1, 4'h0, 4'h1, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0);
    tbl[17] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    tbl[18] = v(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    tbl[19] = v(0, 1, 4'h0, 4'h1, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0);
    tbl[20] = v(0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    tbl[21] = v(0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0, 4'd0, 0, 1, 1);
    tbl[22] = v(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    tbl[23] = v(0, 1, 4'h9, 4'hA, 0, 0, 0, 4'd9, 4'd9, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].mr, tbl[i].ld, tbl[i].lt, tbl[i].lo, tbl[i].st, tbl[i].sp, tbl[i].tk);
      chk($sformatf("tbl[%0d]", i), out0(), tbl[i].exp);
    end

    // Full borrow chain 12 -> 00, then a spare tick in DONE.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'h1, 4'h2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int val;
      val = 11 - i;
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("borrow[%0d]", i), out0(),
          {4'(val / 10), 4'(val % 10), val != 0, val == 0, val == 0});
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("borrow_extra_tick", out0(), {4'd0, 4'd0, 1'b0, 1'b1, 1'b0});

    // Pause with a coincident tick, then resume to expiry.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'h0, 4'h5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pause_pre", out0(), {4'd0, 4'd3, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("pause_stop_tick", out0(), {4'd0, 4'd3, 1'b0, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pause_hold_tick", out0(), {4'd0, 4'd3, 1'b0, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("pause_resume", out0(), {4'd0, 4'd3, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pause_expire", out0(), {4'd0, 4'd0, 1'b0, 1'b1, 1'b1});

    // Auto reload: 02 -> 01 -> 00 (expire) -> 02, staying in RUN.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'h0, 4'h2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ar_01", out1(), {4'd0, 4'd1, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ar_00", out1(), {4'd0, 4'd0, 1'b1, 1'b0, 1'b1});
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ar_reload", out1(), {4'd0, 4'd2, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ar_after", out1(), {4'd0, 4'd1, 1'b1, 1'b0, 1'b0});

    // Auto reload with a 00 load: start parks in DONE with done low.
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 4'h0, 4'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("ar_zero_start", out1(), {4'd0, 4'd0, 1'b0, 1'b0, 1'b0});

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 1) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
